// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MISS        = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_DONE = 3'd4
    } state_e;

    // Value driven on mem_write_o for each kind of memory request
    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    function automatic int calc_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - calc_idx_w(sets) - calc_off_w(line_w);
    endfunction

    // Way-number width; a single-way cache still carries a 1-bit way field
    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_assoc_if.sv
// CPU-side (p1_*) and memory-side (mem_*) signal bundle of the data cache.
// Latency: n/a (wires only).
// Backpressure: CPU held by p1_stall_o; memory completes with mem_ack_i.
// Modports: slave = cache view, master = CPU/memory environment view.
interface dcache_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       p1_data_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    modport slave (
        input  mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
    );

    modport master (
        output mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
    );
endinterface

// File: rtl/dcache_repl.sv
// Per-set replacement state: proposes a victim way for the addressed set.
// Latency: victim_way_o is combinational from set_idx_i; touch updates on the next edge.
// Backpressure: none; a touch is accepted every cycle touch_vld_i is high.
// Ports: set_idx_i selects the set for both lookup and update; touch_way_i/touch_vld_i
// mark an access. Macro DCACHE_LRU_EN selects true LRU ages, otherwise a round-robin pointer.
module dcache_repl
    import dcache_pkg::*;
#(
    parameter  int SETS  = 32,
    parameter  int WAYS  = 2,
    localparam int IDX_W = calc_idx_w(SETS),
    localparam int WAY_W = calc_way_w(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             touch_vld_i,
    output logic [WAY_W-1:0] victim_way_o
);

`ifdef DCACHE_LRU_EN
    // Ages form a permutation of 0..WAYS-1 per set; the oldest way has age WAYS-1.
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];
    logic [WAY_W-1:0] old_age;
    logic [WAY_W-1:0] max_age;

    always_comb begin
        age_d   = age_q;
        old_age = age_q[set_idx_i][touch_way_i];
        if (touch_vld_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_idx_i][w] < old_age) begin
                    age_d[set_idx_i][w] = age_q[set_idx_i][w] + 1'b1;
                end
            end
            age_d[set_idx_i][touch_way_i] = '0;
        end
    end

    always_comb begin
        victim_way_o = '0;
        max_age      = age_q[set_idx_i][0];
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[set_idx_i][w] > max_age) begin
                max_age      = age_q[set_idx_i][w];
                victim_way_o = WAY_W'(w);
            end
        end
    end

    // Cleared state is the identity permutation so the update rule stays a permutation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] ptr_d [SETS];
    logic             unused_touch_way;

    // Round-robin ignores which way was filled; it only counts fills.
    assign unused_touch_way = ^touch_way_i;

    always_comb begin
        ptr_d = ptr_q;
        if (touch_vld_i) begin
            ptr_d[set_idx_i] = (ptr_q[set_idx_i] == WAY_W'(WAYS - 1)) ? '0
                                                                        : ptr_q[set_idx_i] + 1'b1;
        end
    end

    assign victim_way_o = ptr_q[set_idx_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate L1 data cache (p1_* CPU port, mem_* line port).
// Latency: hits are combinational, same cycle; a clean miss resolves in 4 + memory-latency cycles.
// Backpressure: p1_stall_o holds the CPU during a miss; memory requests are held until mem_ack_i.
// Ports: clk_i, rst_i (async, active-low), bus (dcache_assoc_if.slave).
// Macro DCACHE_LRU_EN switches victim choice from round-robin to true LRU (see dcache_repl).
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_assoc_if.slave bus
);

    localparam int OFF_W  = calc_off_w(LINE_W);
    localparam int IDX_W  = calc_idx_w(SETS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_W, SETS);
    localparam int WSEL_W = OFF_W - 2;
    localparam int WAY_W  = calc_way_w(WAYS);

    // Storage arrays
    logic              valid_q [WAYS][SETS];
    logic              valid_d [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic              dirty_d [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] line_q  [WAYS][SETS];

    // Control state
    state_e            state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    logic [TAG_W-1:0]  p1_tag;
    logic [IDX_W-1:0]  p1_idx;
    logic [WSEL_W-1:0] p1_word;
    logic              req;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              cpu_acc;
    logic              store_en;
    logic              fill;
    logic [WAY_W-1:0]  victim_sel;
    logic              inv_found;
    logic [WAY_W-1:0]  repl_victim;
    logic [IDX_W-1:0]  repl_idx;
    logic [WAY_W-1:0]  touch_way;
    logic              touch_vld;
    logic              unused_addr_lsb;

    assign p1_tag          = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx          = bus.p1_addr_i[OFF_W +: IDX_W];
    assign p1_word         = bus.p1_addr_i[2 +: WSEL_W];
    assign unused_addr_lsb = ^bus.p1_addr_i[1:0];
    // A simultaneous read and write is handled as a write because store_en keys on MemWrite.
    assign req             = bus.p1_MemRead_i | bus.p1_MemWrite_i;

    // Tag compare; first matching way wins (at most one can match in a consistent cache)
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][p1_idx] && (tag_q[w][p1_idx] == p1_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit = hit & req;
    end

    // CPU may only consume a hit in IDLE or in the cycle right after a refill
    assign cpu_acc  = hit & ((state_q == S_IDLE) || (state_q == S_REFILL_DONE));
    assign store_en = cpu_acc & bus.p1_MemWrite_i;

    assign bus.p1_stall_o = req & ~hit;
    assign bus.p1_data_o  = hit ? line_q[hit_way][p1_idx][{p1_word, 5'd0} +: 32] : 32'd0;

    // Lowest invalid way beats the replacement policy
    always_comb begin
        inv_found  = 1'b0;
        victim_sel = repl_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[w][miss_idx_q]) begin
                inv_found  = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    assign repl_idx = (state_q == S_IDLE) ? p1_idx : miss_idx_q;

`ifdef DCACHE_LRU_EN
    assign touch_vld = fill | cpu_acc;
    assign touch_way = fill ? victim_q : hit_way;
`else
    assign touch_vld = fill;
    assign touch_way = victim_q;
`endif

    dcache_repl #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_repl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_idx_i    (repl_idx),
        .touch_way_i  (touch_way),
        .touch_vld_i  (touch_vld),
        .victim_way_o (repl_victim)
    );

    // Miss FSM; memory-side outputs are registered so they change only on the clock
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        fill         = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Latch the miss address so a dropped request still completes its fill
                if (req && !hit) begin
                    state_d    = S_MISS;
                    miss_tag_d = p1_tag;
                    miss_idx_d = p1_idx;
                end
            end
            S_MISS: begin
                victim_d     = victim_sel;
                mem_enable_d = 1'b1;
                if (valid_q[victim_sel][miss_idx_q] && dirty_q[victim_sel][miss_idx_q]) begin
                    state_d     = S_WRITEBACK;
                    mem_write_d = MEM_CMD_WRITE;
                    mem_addr_d  = {tag_q[victim_sel][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
                    mem_data_d  = line_q[victim_sel][miss_idx_q];
                end else begin
                    state_d     = S_REFILL;
                    mem_write_d = MEM_CMD_READ;
                    mem_addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                end
            end
            S_WRITEBACK: begin
                // Enable stays high straight into the refill request
                if (bus.mem_ack_i) begin
                    state_d     = S_REFILL;
                    mem_write_d = MEM_CMD_READ;
                    mem_addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                end
            end
            S_REFILL: begin
                if (bus.mem_ack_i) begin
                    fill         = 1'b1;
                    state_d      = S_REFILL_DONE;
                    mem_enable_d = 1'b0;
                end
            end
            S_REFILL_DONE: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill) begin
            valid_d[victim_q][miss_idx_q] = 1'b1;
            dirty_d[victim_q][miss_idx_q] = 1'b0;
        end
        if (store_en) begin
            dirty_d[hit_way][p1_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            victim_q     <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Tag and line contents carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
            line_q[victim_q][miss_idx_q] <= bus.mem_data_i;
        end
        if (store_en) begin
            line_q[hit_way][p1_idx][{p1_word, 5'd0} +: 32] <= bus.p1_data_i;
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (ADDR_W=32, LINE_W=256, SETS=32, WAYS=2).
// Latency: n/a.
// Backpressure: the bench plays CPU and memory, holding requests while stalled.
module tb_dcache_assoc;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dcache_assoc_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    dcache_assoc #(
        .ADDR_W (32),
        .LINE_W (256),
        .SETS   (32),
        .WAYS   (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.p1_MemRead_i  = rd;
        bus.p1_MemWrite_i = wr;
        bus.p1_addr_i     = a;
        bus.p1_data_i     = d;
        #1;
    endtask

    // Line whose word i holds base + i
    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Wait (bounded) for a memory request, check it, then ack after lat cycles
    task automatic serve(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                         input int lat, input logic [255:0] rline, output logic [255:0] wline);
        int n = 0;
        while (!bus.mem_enable_o && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_en"}, 256'(bus.mem_enable_o), 256'(1));
        chk({tag, "_wr"}, 256'(bus.mem_write_o), 256'(exp_wr));
        chk({tag, "_addr"}, 256'(bus.mem_addr_o), 256'(exp_addr));
        wline = bus.mem_data_o;
        repeat (lat) step();
        chk({tag, "_stall"}, 256'(bus.p1_stall_o), 256'(1));
        chk({tag, "_hold"}, 256'(bus.mem_enable_o), 256'(1));
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = rline;
        step();
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] wl;
        logic [255:0] exp_a;
        int           n;

        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.mem_ack_i     = 1'b0;
        bus.mem_data_i    = '0;
        rst_n             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 256'(bus.mem_enable_o), 256'(0));
        chk("rst_wr", 256'(bus.mem_write_o), 256'(0));
        chk("rst_addr", 256'(bus.mem_addr_o), 256'(0));
        chk("rst_mdata", bus.mem_data_o, 256'(0));
        rst_n = 1'b1;
        step();
        chk("idle_stall", 256'(bus.p1_stall_o), 256'(0));
        chk("idle_data", 256'(bus.p1_data_o), 256'(0));

        // 1: load miss, refill from 0x400, word1 = DEADBEEF
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("t1_stall", 256'(bus.p1_stall_o), 256'(1));
        chk("t1_miss_data", 256'(bus.p1_data_o), 256'(0));
        serve("t1", 1'b0, 32'h0000_0400, 10, mkline(32'hDEAD_BEEE), wl);
        chk("t1_stall_drop", 256'(bus.p1_stall_o), 256'(0));
        chk("t1_data", 256'(bus.p1_data_o), 256'(32'hDEAD_BEEF));
        chk("t1_en_drop", 256'(bus.mem_enable_o), 256'(0));
        step();
        chk("t1_data_idle", 256'(bus.p1_data_o), 256'(32'hDEAD_BEEF));

        // 2: store hit, then reload
        cpu(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678);
        chk("t2_st_stall", 256'(bus.p1_stall_o), 256'(0));
        step();
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("t2_reload", 256'(bus.p1_data_o), 256'(32'h1234_5678));
        cpu(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        chk("t2_neighbour", 256'(bus.p1_data_o), 256'(32'hDEAD_BEEE));
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2_mem_idle", 256'(bus.mem_enable_o), 256'(0));

        // 3: reset, fill set 0 with A and B, dirty A, then access C = 0x800
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("t3_rst_inval", 256'(bus.p1_stall_o), 256'(1));
        cpu(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        serve("t3a", 1'b0, 32'h0000_0000, 2, mkline(32'hA000_0000), wl);
        chk("t3a_data", 256'(bus.p1_data_o), 256'(32'hA000_0000));
        step();
        cpu(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D);
        chk("t3_st_stall", 256'(bus.p1_stall_o), 256'(0));
        step();
        cpu(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        serve("t3b", 1'b0, 32'h0000_0400, 2, mkline(32'hB000_0000), wl);
        chk("t3b_data", 256'(bus.p1_data_o), 256'(32'hB000_0000));
        step();
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        exp_a             = mkline(32'hA000_0000);
        exp_a[95:64]      = 32'hCAFE_F00D;
        serve("t3wb", 1'b1, 32'h0000_0000, 3, '0, wl);
        chk("t3wb_line", wl, exp_a);
        chk("t3_wb2rf_en", 256'(bus.mem_enable_o), 256'(1));
        chk("t3_wb2rf_wr", 256'(bus.mem_write_o), 256'(0));
        chk("t3_wb2rf_addr", 256'(bus.mem_addr_o), 256'(32'h0000_0800));
        serve("t3c", 1'b0, 32'h0000_0800, 4, mkline(32'hC000_0000), wl);
        chk("t3c_data", 256'(bus.p1_data_o), 256'(32'hC000_0000));
        step();
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("t3_b_kept", 256'(bus.p1_data_o), 256'(32'hB000_0001));
        cpu(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        chk("t3_a_evicted", 256'(bus.p1_stall_o), 256'(1));
        cpu(1'b1, 1'b0, 32'h0000_0804, 32'h0);
        chk("t3_c_hit", 256'(bus.p1_data_o), 256'(32'hC000_0001));
        step();

        // 4: clean victim (B) -> straight to refill, no write-back
        cpu(1'b1, 1'b0, 32'h0000_0C00, 32'h0);
        serve("t4", 1'b0, 32'h0000_0C00, 3, mkline(32'hD000_0000), wl);
        chk("t4_data", 256'(bus.p1_data_o), 256'(32'hD000_0000));
        step();
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        chk("t4_c_kept_stall", 256'(bus.p1_stall_o), 256'(0));
        chk("t4_c_kept_data", 256'(bus.p1_data_o), 256'(32'hC000_0000));
        step();

        // 5: reset during refill
        cpu(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        n = 0;
        while (!bus.mem_enable_o && n < 20) begin
            step();
            n++;
        end
        chk("t5_refill_en", 256'(bus.mem_enable_o), 256'(1));
        chk("t5_refill_wr", 256'(bus.mem_write_o), 256'(0));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_en", 256'(bus.mem_enable_o), 256'(0));
        chk("t5_rst_addr", 256'(bus.mem_addr_o), 256'(0));
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        chk("t5_lost_line", 256'(bus.p1_stall_o), 256'(1));
        serve("t5", 1'b0, 32'h0000_0800, 2, mkline(32'hE000_0000), wl);
        chk("t5_data", 256'(bus.p1_data_o), 256'(32'hE000_0000));
        step();
        cpu(1'b0, 1'b0, 32'h0, 32'h0);

        // 6: stray ack in IDLE is ignored
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = '1;
        step();
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        chk("t6_en", 256'(bus.mem_enable_o), 256'(0));
        step();
        chk("t6_en_later", 256'(bus.mem_enable_o), 256'(0));
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        chk("t6_stall", 256'(bus.p1_stall_o), 256'(0));
        chk("t6_data", 256'(bus.p1_data_o), 256'(32'hE000_0000));
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("t6_no_fill", 256'(bus.p1_stall_o), 256'(1));
        cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
